// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and data memory (slave).
// Request/grant handshake plus a separate read-response channel.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data-memory bus, stalls the pipeline while a
// load is outstanding and formats load/store data. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            alu_result_mem,
  input  logic [31:0]            write_data_mem,
  input  logic [2:0]             funct3_mem,
  input  logic [1:0]             result_src_mem,
  input  logic                   mem_write_mem,
  input  logic                   flush_mem,
  mem_stage_lsu_if.master        dmem,
  output logic [31:0]            read_data_mem,
  output logic                   stall_mem,
  output logic                   bus_err,
  output logic                   misalign_exc
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             kill_q;

  logic       is_load, is_store, access, misalign, timeout;
  logic [1:0] off;
  logic [1:0] size;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign off      = alu_result_mem[1:0];
  assign size     = funct3_mem[1:0];
  assign is_store = mem_write_mem;
  assign is_load  = (result_src_mem == 2'b01) && !mem_write_mem;
  assign access   = (is_load || is_store) && !flush_mem;
  assign timeout  = (state_q == S_WAIT) && (cnt_q == TIMEOUT_CNT) && !dmem.dmem_rvalid;

`ifdef MISALIGN_TRAP_EN
  assign misalign = access && (((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    st_wdata = write_data_mem;
    st_be    = 4'b1111;
    case (size)
      2'b00: begin
        st_wdata = {4{write_data_mem[7:0]}};
        st_be    = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{write_data_mem[15:0]}};
        st_be    = 4'b0011 << {off[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem.dmem_rdata[7:0];
    case (off_q)
      2'b01:   ld_byte = dmem.dmem_rdata[15:8];
      2'b10:   ld_byte = dmem.dmem_rdata[23:16];
      2'b11:   ld_byte = dmem.dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  // Outputs are gated by reset so nothing leaks onto the bus while reset is held.
  always_comb begin
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = 32'h0;
    dmem.dmem_wdata = 32'h0;
    dmem.dmem_be    = 4'b0000;
    read_data_mem   = 32'h0;
    stall_mem       = 1'b0;
    bus_err         = 1'b0;
    misalign_exc    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (misalign) begin
            misalign_exc = 1'b1;
          end else if (access) begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = is_store;
            dmem.dmem_addr  = {alu_result_mem[31:2], 2'b00};
            dmem.dmem_wdata = st_wdata;
            dmem.dmem_be    = st_be;
            stall_mem       = !(is_store && dmem.dmem_gnt);
          end
        end
        S_WAIT: begin
          stall_mem = !(dmem.dmem_rvalid || timeout);
          bus_err   = timeout;
          if (dmem.dmem_rvalid && !kill_q && !flush_mem) begin
            read_data_mem = ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      kill_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access && !misalign && is_load && dmem.dmem_gnt) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            off_q   <= off;
            f3_q    <= funct3_mem;
            kill_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A flush while waiting only discards the eventual data; the bus still drains.
          if (flush_mem) kill_q <= 1'b1;
          if (dmem.dmem_rvalid || timeout) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of single-access format vectors plus
// hand-written multi-cycle sequences (stall timing, timeout, flush, reset).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_mem;
  logic [2:0]  funct3_mem;
  logic [1:0]  result_src_mem;
  logic        mem_write_mem;
  logic        flush_mem;
  logic [31:0] read_data_mem;
  logic        stall_mem;
  logic        bus_err;
  logic        misalign_exc;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_result_mem (alu_result_mem),
    .write_data_mem (write_data_mem),
    .funct3_mem     (funct3_mem),
    .result_src_mem (result_src_mem),
    .mem_write_mem  (mem_write_mem),
    .flush_mem      (flush_mem),
    .dmem           (bus),
    .read_data_mem  (read_data_mem),
    .stall_mem      (stall_mem),
    .bus_err        (bus_err),
    .misalign_exc   (misalign_exc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_result_mem  = 32'h0;
    write_data_mem  = 32'h0;
    funct3_mem      = 3'b000;
    result_src_mem  = 2'b00;
    mem_write_mem   = 1'b0;
    flush_mem       = 1'b0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr);
    result_src_mem = 2'b01;
    mem_write_mem  = 1'b0;
    funct3_mem     = f3;
    alu_result_mem = addr;
  endtask

  task automatic drive_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    result_src_mem = 2'b00;
    mem_write_mem  = 1'b1;
    funct3_mem     = f3;
    alu_result_mem = addr;
    write_data_mem = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        is_load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int stall_cnt;
    int wait_cycles;
    int err_cnt;
    logic seen;

    vecs[0]  = '{"lb@1",   1'b1, 3'b000, 32'h0000_0101, 32'h0, 32'h80FF_7F01, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_007F};
    vecs[1]  = '{"lbu@1",  1'b1, 3'b100, 32'h0000_0101, 32'h0, 32'h80FF_7F01, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_007F};
    vecs[2]  = '{"lh@2",   1'b1, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 32'h0000_0100, 32'h0, 4'h0, 32'hFFFF_80FF};
    vecs[3]  = '{"lhu@2",  1'b1, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_80FF};
    vecs[4]  = '{"lb@3",   1'b1, 3'b000, 32'h0000_0223, 32'h0, 32'h80FF_7F01, 32'h0000_0220, 32'h0, 4'h0, 32'hFFFF_FF80};
    vecs[5]  = '{"lbu@3",  1'b1, 3'b100, 32'h0000_0223, 32'h0, 32'h80FF_7F01, 32'h0000_0220, 32'h0, 4'h0, 32'h0000_0080};
    vecs[6]  = '{"lh@0",   1'b1, 3'b001, 32'h0000_0300, 32'h0, 32'h80FF_7F01, 32'h0000_0300, 32'h0, 4'h0, 32'h0000_7F01};
    vecs[7]  = '{"lw@0",   1'b1, 3'b010, 32'h0000_0304, 32'h0, 32'h80FF_7F01, 32'h0000_0304, 32'h0, 4'h0, 32'h80FF_7F01};
    vecs[8]  = '{"sb@3",   1'b0, 3'b000, 32'h0000_0203, 32'h1234_56A5, 32'h0, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000, 32'h0};
    vecs[9]  = '{"sh@2",   1'b0, 3'b001, 32'h0000_0302, 32'hCAFE_BEEF, 32'h0, 32'h0000_0300, 32'hBEEF_BEEF, 4'b1100, 32'h0};
    vecs[10] = '{"sh@0",   1'b0, 3'b001, 32'h0000_0300, 32'hCAFE_BEEF, 32'h0, 32'h0000_0300, 32'hBEEF_BEEF, 4'b0011, 32'h0};
    vecs[11] = '{"sw",     1'b0, 3'b010, 32'h0000_0404, 32'h1122_3344, 32'h0, 32'h0000_0404, 32'h1122_3344, 4'b1111, 32'h0};

    // Reset with a load presented: everything stays low.
    drive_idle();
    reset = 1'b1;
    drive_load(3'b010, 32'h0000_0100);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    check("rst_req",   {31'h0, bus.dmem_req}, 32'h0);
    check("rst_stall", {31'h0, stall_mem},    32'h0);
    check("rst_rdata", read_data_mem,         32'h0);
    check("rst_err",   {30'h0, bus_err, misalign_exc}, 32'h0);
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
    check("idle_req",  {31'h0, bus.dmem_req}, 32'h0);

    // Table-driven single accesses, memory granting immediately.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (vecs[i].is_load) drive_load(vecs[i].f3, vecs[i].addr);
      else                 drive_store(vecs[i].f3, vecs[i].addr, vecs[i].wd);
      bus.dmem_gnt = 1'b1;
      @(negedge clk);
      check({vecs[i].name, "_addr"}, bus.dmem_addr, vecs[i].exp_addr);
      check({vecs[i].name, "_we"}, {31'h0, bus.dmem_we}, {31'h0, !vecs[i].is_load});
      check({vecs[i].name, "_stall"}, {31'h0, stall_mem}, {31'h0, vecs[i].is_load});
      if (vecs[i].is_load) begin
        next_cycle();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = vecs[i].rdata;
        @(negedge clk);
        check({vecs[i].name, "_rd"}, read_data_mem, vecs[i].exp_rd);
        check({vecs[i].name, "_rdstall"}, {31'h0, stall_mem}, 32'h0);
      end else begin
        check({vecs[i].name, "_wdata"}, bus.dmem_wdata, vecs[i].exp_wdata);
        check({vecs[i].name, "_be"}, {28'h0, bus.dmem_be}, {28'h0, vecs[i].exp_be});
      end
      next_cycle();
      drive_idle();
    end

    // LW 0x100, granted at once, rvalid after one empty WAIT cycle: stall for 2 cycles.
    next_cycle();
    drive_load(3'b010, 32'h0000_0100);
    bus.dmem_gnt = 1'b1;
    stall_cnt = 0;
    @(negedge clk);
    check("lw_addr", bus.dmem_addr, 32'h0000_0100);
    if (stall_mem) stall_cnt++;
    next_cycle();
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    check("lw_wait_req", {31'h0, bus.dmem_req}, 32'h0);
    check("lw_wait_rd", read_data_mem, 32'h0);
    if (stall_mem) stall_cnt++;
    next_cycle();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("lw_rd", read_data_mem, 32'hDEAD_BEEF);
    if (stall_mem) stall_cnt++;
    check("lw_stall_cycles", stall_cnt, 2);
    next_cycle();
    drive_idle();
    bus.dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("lw_after_rd", read_data_mem, 32'h0);

    // SB 0x203, grant delayed by 3 cycles: request held stable, stall exactly 3 cycles.
    next_cycle();
    drive_store(3'b000, 32'h0000_0203, 32'h0000_00A5);
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      bus.dmem_gnt = (c == 3);
      @(negedge clk);
      check("sb_req",   {31'h0, bus.dmem_req}, 32'h1);
      check("sb_addr",  bus.dmem_addr, 32'h0000_0200);
      check("sb_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
      check("sb_be",    {28'h0, bus.dmem_be}, 32'h8);
      if (stall_mem) stall_cnt++;
      next_cycle();
    end
    check("sb_stall_cycles", stall_cnt, 3);
    drive_idle();

    // LW granted, no response: bus_err on the 17th WAIT cycle, then a late rvalid is ignored.
    next_cycle();
    drive_load(3'b010, 32'h0000_0500);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    wait_cycles = 0;
    err_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      next_cycle();
      bus.dmem_gnt = 1'b0;
      @(negedge clk);
      wait_cycles++;
      if (bus_err) begin
        seen = 1'b1;
        err_cnt++;
        check("to_stall", {31'h0, stall_mem}, 32'h0);
        check("to_rd", read_data_mem, 32'h0);
      end else if (!stall_mem) begin
        check("to_early_stall_drop", 32'h0, 32'h1);
      end
    end
    check("to_seen", {31'h0, seen}, 32'h1);
    check("to_wait_cycles", wait_cycles, 17);
    next_cycle();
    drive_idle();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1234_5678;
    @(negedge clk);
    if (bus_err) err_cnt++;
    check("to_err_pulses", err_cnt, 1);
    check("late_rv_rd", read_data_mem, 32'h0);
    check("late_rv_stall", {31'h0, stall_mem}, 32'h0);
    next_cycle();
    drive_idle();

    // Flush suppresses a store still waiting for its grant.
    next_cycle();
    drive_store(3'b010, 32'h0000_0600, 32'hFFFF_0000);
    @(negedge clk);
    check("fl_req_before", {31'h0, bus.dmem_req}, 32'h1);
    check("fl_stall_before", {31'h0, stall_mem}, 32'h1);
    next_cycle();
    flush_mem = 1'b1;
    @(negedge clk);
    check("fl_req", {31'h0, bus.dmem_req}, 32'h0);
    check("fl_stall", {31'h0, stall_mem}, 32'h0);
    next_cycle();
    drive_idle();

    // Flush while waiting: transaction drains but the data is discarded.
    next_cycle();
    drive_load(3'b010, 32'h0000_0700);
    bus.dmem_gnt = 1'b1;
    next_cycle();
    bus.dmem_gnt = 1'b0;
    flush_mem = 1'b1;
    @(negedge clk);
    check("flw_stall", {31'h0, stall_mem}, 32'h1);
    next_cycle();
    flush_mem = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    check("flw_rd", read_data_mem, 32'h0);
    check("flw_stall_drop", {31'h0, stall_mem}, 32'h0);
    next_cycle();
    drive_idle();

    // rvalid coinciding with the grant is not the response.
    next_cycle();
    drive_load(3'b010, 32'h0000_0800);
    bus.dmem_gnt    = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    check("gr_rd_idle", read_data_mem, 32'h0);
    check("gr_stall_idle", {31'h0, stall_mem}, 32'h1);
    next_cycle();
    bus.dmem_gnt   = 1'b0;
    bus.dmem_rdata = 32'h0000_0055;
    @(negedge clk);
    check("gr_rd_wait", read_data_mem, 32'h0000_0055);
    next_cycle();
    drive_idle();

    // Reset in WAIT: outputs drop at once and the pending response is ignored.
    next_cycle();
    drive_load(3'b010, 32'h0000_0900);
    bus.dmem_gnt = 1'b1;
    next_cycle();
    bus.dmem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    check("rw_req",   {31'h0, bus.dmem_req}, 32'h0);
    check("rw_stall", {31'h0, stall_mem},    32'h0);
    check("rw_rd",    read_data_mem,         32'h0);
    check("rw_err",   {31'h0, bus_err},      32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h7777_7777;
    next_cycle();
    @(negedge clk);
    check("rw_late_rd", read_data_mem, 32'h0);
    next_cycle();
    drive_idle();

    // Misaligned LW at 0x102.
    next_cycle();
    drive_load(3'b010, 32'h0000_0102);
    @(negedge clk);
`ifdef MISALIGN_TRAP_EN
    check("mis_exc",   {31'h0, misalign_exc}, 32'h1);
    check("mis_req",   {31'h0, bus.dmem_req}, 32'h0);
    check("mis_stall", {31'h0, stall_mem},    32'h0);
`else
    check("mis_exc",   {31'h0, misalign_exc}, 32'h0);
    check("mis_req",   {31'h0, bus.dmem_req}, 32'h1);
    check("mis_addr",  bus.dmem_addr,         32'h0000_0100);
`endif
    next_cycle();
    drive_idle();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register.
- Converts EX/MEM control and data into a request/grant/response transaction on the data-memory bus.
- Stalls the pipeline while a transaction is outstanding.
- Formats load data (byte/half extraction, sign/zero extend) and store data (byte-lane replication, byte enables).

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT before the load is aborted with bus_err.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_result_mem  in  32  effective address.
- write_data_mem  in  32  store source register value.
- funct3_mem  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- result_src_mem  in  2  01 = load; other values = not a load.
- mem_write_mem  in  1  store.
- flush_mem  in  1  kill the instruction currently in MEM.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address; bits [1:0] = 00.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- read_data_mem  out  32  formatted load result to MEM/WB.
- stall_mem  out  1  to hazard unit; holds PC, IF/ID, ID/EX and EX/MEM.
- bus_err  out  1  one-cycle pulse: load timed out.
- misalign_exc  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Access is defined as (result_src_mem==01 or mem_write_mem) and not flush_mem.
- FSM states: IDLE, WAIT.
- Reset: state=IDLE, counter=0, captured offset/funct3=0. All outputs are 0 during and after reset.
- IDLE, no access: dmem_req=0, stall_mem=0.
- IDLE, access:
  - dmem_req=1 combinationally; dmem_we=mem_write_mem; dmem_addr={addr[31:2],2'b00}.
  - stall_mem = !(store && dmem_gnt), i.e. stall until a store is granted, and always stall for a load.
- IDLE, store granted: done; remain in IDLE; the next instruction presents on the following cycle.
- IDLE, load granted:
  - Capture addr[1:0] and funct3; go to WAIT; clear counter.
  - Request is dropped the next cycle.
- No grant: hold dmem_req and all request fields stable until granted. Requests are never withdrawn.
- WAIT:
  - dmem_req=0; counter increments each cycle.
  - stall_mem = !dmem_rvalid.
  - On dmem_rvalid: read_data_mem is formatted combinationally from dmem_rdata using the captured offset/funct3; stall_mem=0; return to IDLE.
  - read_data_mem is valid only in that cycle; 0 otherwise.
- Timeout: counter==TIMEOUT_CYCLES without rvalid -> bus_err=1 for one cycle, read_data_mem=0, stall_mem=0, return to IDLE.
  - A late rvalid arriving in IDLE is ignored.
- Load formatting:
  - Byte: lane = rdata[8*off+:8].
  - Half: lane = rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store formatting:
  - SB: wdata = {4{wd[7:0]}}, be = 0001<<off.
  - SH: wdata = {2{wd[15:0]}}, be = 0011<<(2*off[1]).
  - SW: be = 1111.
- Flush:
  - flush_mem in IDLE before grant suppresses the request.
  - flush_mem in WAIT does not abort: the unit drains to rvalid or timeout, but read_data_mem is forced to 0 for that completion.
- Simultaneous gnt and rvalid in the same IDLE cycle: rvalid is ignored; only a response in WAIT counts.
- Reset mid-transaction: immediate return to IDLE, request dropped; any pending response is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=00, raise misalign_exc=1 for one cycle in IDLE.
  - No bus request is issued, stall_mem=0, read_data_mem=0.
- Undefined:
  - misalign_exc tied 0.
  - Misaligned offsets are silently truncated: half uses off[1], word ignores off.

Test Plan:
- LW at 0x100, gnt in the same cycle, rvalid one cycle later with rdata=0xDEADBEEF -> dmem_addr=0x100; stall_mem high for 2 cycles; read_data_mem=0xDEADBEEF in the rvalid cycle.
- SB addr 0x203, wd=0x000000A5, gnt delayed 3 cycles -> dmem_be=1000, dmem_wdata=0xA5A5A5A5 held stable; stall_mem high exactly 3 cycles.
- LB/LBU/LH/LHU at offsets 1 and 2 with rdata=0x80FF7F01:
  - LB@1 -> 0x0000007F.
  - LBU@1 -> 0x0000007F.
  - LH@2 -> 0xFFFF80FF.
  - LHU@2 -> 0x000080FF.
- LW granted, rvalid never asserted, TIMEOUT_CYCLES=16 -> bus_err pulses once after 16 WAIT cycles; stall drops; a late rvalid is ignored.
- flush_mem with a store pending and no grant -> dmem_req falls to 0, stall_mem=0. Reset asserted in WAIT -> all outputs 0 immediately.
- With MISALIGN_TRAP_EN: LW at 0x102 -> misalign_exc=1, dmem_req stays 0.
